pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core; sits beside the IF/ID, ID/EX and EX/MEM registers.

---
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/redirect/freeze/halt sequencer for the 5-stage core.
// Drives the write-enable and flush controls of the IF/ID, ID/EX and EX/MEM
// registers, drains the pipe after HALT and keeps a saturating stall counter.
// Optional feature macro: FORWARDING_EN (EX->ID forwarding present, so only
// load-use stalls). Default build has no forwarding.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_valid,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_valid,
    input  logic             id_halt,
    input  logic             ex_memRead,
    input  logic             ex_regWrite,
    input  logic [2:0]       ex_writereg,
    input  logic             mem_regWrite,
    input  logic [2:0]       mem_writereg,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             exmemWrite,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, FREEZE, DRAIN, HALTED} state_t;

    state_t           state, stateNxt;
    logic             pendRedirect, pendNxt;
    logic [DCW-1:0]   drainCnt, drainNxt;
    logic [CNT_W-1:0] stallCnt;
    logic             hzEx, hzMem, hzLoadUse, hazard;
    logic             pcWr, ifidWr, ifidFl, idexFl, exmemWr;
    logic             stallInc;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign hzEx = ex_regWrite &
                  ((id_rs_valid & (id_rs == ex_writereg)) |
                   (id_rt_valid & (id_rt == ex_writereg)));
    assign hzMem = mem_regWrite &
                   ((id_rs_valid & (id_rs == mem_writereg)) |
                    (id_rt_valid & (id_rt == mem_writereg)));
    assign hzLoadUse = hzEx & ex_memRead;

`ifdef FORWARDING_EN
    // EX results forward to ID, only a load still in EX forces a bubble
    assign hazard = hzLoadUse;
`else
    // No forwarding: wait until the producer leaves MEM (load-use is a subset of hzEx)
    assign hazard = hzLoadUse | hzEx | hzMem;
`endif

    // Next-state and control decode; FREEZE with memory ready resolves like RUN
    always_comb begin
        stateNxt = state;
        pendNxt  = pendRedirect;
        drainNxt = drainCnt;
        pcWr     = 1'b1;
        ifidWr   = 1'b1;
        ifidFl   = 1'b0;
        idexFl   = 1'b0;
        exmemWr  = 1'b1;
        if (state == HALTED) begin
            pcWr    = 1'b0;
            ifidWr  = 1'b0;
            exmemWr = 1'b0;
            ifidFl  = 1'b1;
            idexFl  = 1'b1;
        end else if (state == DRAIN) begin
            pcWr    = 1'b0;
            ifidFl  = 1'b1;
            idexFl  = 1'b1;
            exmemWr = !mem_busy;
            if (mem_busy) begin
                // memory stall outranks the redirect; keep it for later
                if (ex_redirect) pendNxt = 1'b1;
            end else if (ex_redirect || pendRedirect) begin
                // HALT was on the wrong path: refetch from the redirect target
                pcWr     = 1'b1;
                exmemWr  = 1'b1;
                pendNxt  = 1'b0;
                drainNxt = '0;
                stateNxt = RUN;
            end else if (drainCnt == '0) begin
                stateNxt = HALTED;
            end else begin
                drainNxt = drainCnt - 1'b1;
            end
        end else if (mem_busy) begin
            pcWr     = 1'b0;
            ifidWr   = 1'b0;
            exmemWr  = 1'b0;
            stateNxt = FREEZE;
            if (ex_redirect) pendNxt = 1'b1;
        end else if (ex_redirect || pendRedirect) begin
            // wrong-path instructions in IF and ID are squashed
            ifidFl   = 1'b1;
            idexFl   = 1'b1;
            pendNxt  = 1'b0;
            stateNxt = RUN;
        end else if (hazard) begin
            pcWr     = 1'b0;
            ifidWr   = 1'b0;
            idexFl   = 1'b1;
            stateNxt = RUN;
        end else if (id_halt) begin
            // HALT moves into EX; nothing behind it enters
            pcWr     = 1'b0;
            ifidFl   = 1'b1;
            drainNxt = DCW'(DRAIN_CYCLES - 1);
            stateNxt = DRAIN;
        end else begin
            stateNxt = RUN;
        end
    end

    // Output drive; reset forces the safe (frozen, flushed) controls
    always_comb begin
        pcWrite    = pcWr;
        ifidWrite  = ifidWr;
        ifidFlush  = ifidFl;
        idexFlush  = idexFl;
        exmemWrite = exmemWr;
        if (!rst) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            exmemWrite = 1'b0;
        end
    end

    assign stallInc    = ((state == RUN) || (state == FREEZE)) && !pcWr;
    assign halted      = (state == HALTED);
    assign stall_count = stallCnt;

    // Sequencer state, pending redirect, drain counter and stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            pendRedirect <= 1'b0;
            drainCnt     <= '0;
            stallCnt     <= '0;
        end else begin
            state        <= stateNxt;
            pendRedirect <= pendNxt;
            drainCnt     <= drainNxt;
            if (stallInc) stallCnt <= satInc(stallCnt);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each driven cycle pushes its
// expected controls; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite}
    localparam logic [4:0] RSTV    = 5'b00110;
    localparam logic [4:0] NORM    = 5'b11000 | 5'b00001;
    localparam logic [4:0] STALL   = 5'b00011;
    localparam logic [4:0] REDIR   = 5'b11111;
    localparam logic [4:0] FRZ     = 5'b00000;
    localparam logic [4:0] HALTRUN = 5'b01101;
    localparam logic [4:0] DRAINV  = 5'b01111;
    localparam logic [4:0] DRBUSY  = 5'b01110;
    localparam logic [4:0] HALTEDV = 5'b00110;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] id_rs, id_rt, ex_writereg, mem_writereg;
    logic id_rs_valid, id_rt_valid, id_halt, ex_memRead, ex_regWrite;
    logic mem_regWrite, ex_redirect, mem_busy;
    logic pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite, halted;
    logic [CNT_W-1:0] stall_count;

    typedef struct {
        logic [4:0] ctl;
        logic       hlt;
        int         cnt;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int checks = 0;
    int errors = 0;
    int expCnt = 0;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rs_valid(id_rs_valid),
        .id_rt(id_rt), .id_rt_valid(id_rt_valid),
        .id_halt(id_halt),
        .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite), .ex_writereg(ex_writereg),
        .mem_regWrite(mem_regWrite), .mem_writereg(mem_writereg),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
        .idexFlush(idexFlush), .exmemWrite(exmemWrite),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input logic [4:0] ctl, input logic hlt, input bit counts, input string tag);
        exp_t e;
        e.ctl = ctl;
        e.hlt = hlt;
        e.cnt = expCnt;
        e.tag = tag;
        sb.push_back(e);
        if (counts && expCnt < CNT_MAX) expCnt++;
    endtask

    task automatic idle();
        id_rs = 3'd0; id_rs_valid = 1'b0; id_rt = 3'd0; id_rt_valid = 1'b0;
        id_halt = 1'b0; ex_memRead = 1'b0; ex_regWrite = 1'b0; ex_writereg = 3'd0;
        mem_regWrite = 1'b0; mem_writereg = 3'd0; ex_redirect = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    // load r2 in EX, ID instruction reads r2 and r1
    task automatic loadUse();
        id_rs = 3'd2; id_rs_valid = 1'b1; id_rt = 3'd1; id_rt_valid = 1'b1;
        ex_memRead = 1'b1; ex_regWrite = 1'b1; ex_writereg = 3'd2;
    endtask

    // Compare the DUT against the oldest pending expectation
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            checkVal({cur.tag, ".ctl"}, {27'd0, pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite}, {27'd0, cur.ctl});
            checkVal({cur.tag, ".halted"}, {31'd0, halted}, {31'd0, cur.hlt});
            checkVal({cur.tag, ".cnt"}, {{(32-CNT_W){1'b0}}, stall_count}, cur.cnt);
        end
    end

    initial begin
        rst = 1'b0;
        idle();
        tick(); pushExp(RSTV, 0, 0, "rst0");
        tick(); pushExp(RSTV, 0, 0, "rst1");
        tick(); rst = 1'b1; pushExp(NORM, 0, 0, "run0");

        // load-use adjacent, then producer in MEM
        tick(); loadUse(); pushExp(STALL, 0, 1, "lu_ex");
        tick(); id_rs = 3'd2; id_rs_valid = 1'b1; mem_regWrite = 1'b1; mem_writereg = 3'd2;
        pushExp(FWD ? NORM : STALL, 0, !FWD, "lu_mem");
        tick(); pushExp(NORM, 0, 0, "lu_done");

        // independent ALU op and non-matching cases
        tick(); ex_regWrite = 1'b1; ex_writereg = 3'd5; id_rs = 3'd1; id_rs_valid = 1'b1;
        id_rt = 3'd3; id_rt_valid = 1'b1; pushExp(NORM, 0, 0, "indep");
        tick(); ex_regWrite = 1'b1; ex_memRead = 1'b1; ex_writereg = 3'd3; id_rt = 3'd3;
        id_rs = 3'd1; id_rs_valid = 1'b1; pushExp(NORM, 0, 0, "rt_unused");
        tick(); ex_writereg = 3'd1; id_rs = 3'd1; id_rs_valid = 1'b1; pushExp(NORM, 0, 0, "no_wr");
        tick(); mem_regWrite = 1'b1; mem_writereg = 3'd4; id_rt = 3'd4; id_rt_valid = 1'b1;
        pushExp(FWD ? NORM : STALL, 0, !FWD, "mem_rt");
        tick(); ex_regWrite = 1'b1; ex_writereg = 3'd6; id_rs = 3'd6; id_rs_valid = 1'b1;
        pushExp(FWD ? NORM : STALL, 0, !FWD, "alu_use");

        // redirect beats hazard and halt
        tick(); loadUse(); ex_redirect = 1'b1; pushExp(REDIR, 0, 0, "redir_hz");
        tick(); pushExp(NORM, 0, 0, "after_redir");
        tick(); id_halt = 1'b1; ex_redirect = 1'b1; pushExp(REDIR, 0, 0, "redir_halt");
        tick(); pushExp(NORM, 0, 0, "no_drain");

        // freeze with a redirect arriving in cycle 2
        tick(); mem_busy = 1'b1; pushExp(FRZ, 0, 1, "frz1");
        tick(); mem_busy = 1'b1; ex_redirect = 1'b1; pushExp(FRZ, 0, 1, "frz2");
        tick(); mem_busy = 1'b1; pushExp(FRZ, 0, 1, "frz3");
        tick(); mem_busy = 1'b1; pushExp(FRZ, 0, 1, "frz4");
        tick(); pushExp(REDIR, 0, 0, "frz_exit");
        tick(); pushExp(NORM, 0, 0, "frz_after");
        tick(); mem_busy = 1'b1; loadUse(); pushExp(FRZ, 0, 1, "busy_hz");
        tick(); loadUse(); pushExp(STALL, 0, 1, "hz_after_frz");

        // halt drain
        tick(); id_halt = 1'b1; pushExp(HALTRUN, 0, 1, "halt_id");
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            tick(); pushExp(DRAINV, 0, 0, "drain");
        end
        tick(); pushExp(HALTEDV, 1, 0, "halted");
        tick(); ex_redirect = 1'b1; id_halt = 1'b1; pushExp(HALTEDV, 1, 0, "halted_redir");
        tick(); pushExp(HALTEDV, 1, 0, "halted_hold");
        tick(); rst = 1'b0; expCnt = 0; pushExp(RSTV, 0, 0, "rst_halt");
        tick(); rst = 1'b1; pushExp(NORM, 0, 0, "post_rst");

        // halt drain stretched by memory busy
        tick(); id_halt = 1'b1; pushExp(HALTRUN, 0, 1, "halt2");
        tick(); mem_busy = 1'b1; pushExp(DRBUSY, 0, 0, "d_busy1");
        tick(); mem_busy = 1'b1; pushExp(DRBUSY, 0, 0, "d_busy2");
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            tick(); pushExp(DRAINV, 0, 0, "drain2");
        end
        tick(); pushExp(HALTEDV, 1, 0, "halted2");
        tick(); rst = 1'b0; expCnt = 0; pushExp(RSTV, 0, 0, "rst_halt2");
        tick(); rst = 1'b1; pushExp(NORM, 0, 0, "post_rst2");

        // wrong-path halt cancelled by redirect in drain
        tick(); id_halt = 1'b1; pushExp(HALTRUN, 0, 1, "halt3");
        tick(); pushExp(DRAINV, 0, 0, "drain3");
        tick(); ex_redirect = 1'b1; pushExp(REDIR, 0, 0, "drain_redir");
        for (int i = 0; i < 4; i++) begin
            tick(); pushExp(NORM, 0, 0, "after_drain_redir");
        end

        // reset in freeze with pending redirect
        tick(); mem_busy = 1'b1; pushExp(FRZ, 0, 1, "frz_r1");
        tick(); mem_busy = 1'b1; ex_redirect = 1'b1; pushExp(FRZ, 0, 1, "frz_r2");
        tick(); rst = 1'b0; expCnt = 0; pushExp(RSTV, 0, 0, "rst_frz");
        tick(); rst = 1'b1; pushExp(NORM, 0, 0, "rst_frz_exit");

        // stall counter saturation
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            tick(); mem_busy = 1'b1; pushExp(FRZ, 0, 1, "sat_busy");
        end
        tick(); pushExp(NORM, 0, 0, "sat_hold");
        tick(); loadUse(); pushExp(STALL, 0, 1, "sat_stall");
        tick(); pushExp(NORM, 0, 0, "sat_end");

        @(posedge clk);
        @(negedge clk);
        #1;
        checkVal("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
